multdiv_unit: RTL

//  Parametrised iterative signed multiply/divide unit for the pipelined processor's execute stage.

---
 rtl/multdiv_pkg.sv | 29 ++
 rtl/multdiv_counter.sv | 28 ++
 rtl/multdiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states and op-select codes.
// Decode uses the same op-select constants to steer mul/div instructions here.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MULT = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIV  = 2'b10
    } op_t;

    // Multiply wins when both start strobes arrive on the same edge.
    function automatic op_t decode_op(input logic mult, input logic div);
        if (mult) begin
            return OP_MUL;
        end
        if (div) begin
            return OP_DIV;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for multdiv_unit: clears on start, counts enabled steps,
// and flags when WIDTH iterations have completed.
module multdiv_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == CNT_W'(WIDTH));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit for the execute stage.
// One iteration per clock; a start strobe in any state aborts the op in flight.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                w_op;
    logic               w_start;
    logic               w_cnt_en;
    logic               w_cnt_done;
    logic               w_finish;

    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH:0]   r_acc;
    logic               r_neg;
    logic               r_dz;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_booth_sum;
    logic [2*WIDTH:0]   w_booth_nxt;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH:0]   w_div_nxt;
    logic [WIDTH:0]     w_prod_hi;
    logic [WIDTH-1:0]   w_quo_mag;
    logic [WIDTH-1:0]   w_res_d;
    logic               w_exc_d;

    assign w_op    = decode_op(ctrl_MULT, ctrl_DIV);
    assign w_start = (w_op != OP_NONE);
    assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    multdiv_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clr   (w_start),
        .i_en    (w_cnt_en),
        .o_done  (w_cnt_done)
    );

    // Booth step: the add is done one bit wider so the shifted-in sign is exact even for MIN.
    always_comb begin
        w_booth_sum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
        case (r_acc[1:0])
            2'b01:   w_booth_sum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]} + {r_opa[WIDTH-1], r_opa};
            2'b10:   w_booth_sum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]} - {r_opa[WIDTH-1], r_opa};
            default: w_booth_sum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
        endcase
        w_booth_nxt = {w_booth_sum, r_acc[WIDTH:1]};
    end

    // Restoring divide step on magnitudes; r_opb holds |divisor| while dividing.
    always_comb begin
        w_div_trial = {1'b0, r_acc[2*WIDTH-2:WIDTH-1]} - {1'b0, r_opb};
        if (!w_div_trial[WIDTH]) begin
            w_div_nxt = {1'b0, w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_nxt = {1'b0, r_acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_prod_hi = r_acc[2*WIDTH:WIDTH];
        w_quo_mag = r_acc[WIDTH-1:0];
        if (r_state == ST_MULT) begin
            w_res_d = r_acc[WIDTH:1];
            w_exc_d = !((&w_prod_hi) || !(|w_prod_hi));
        end else if (r_dz) begin
            w_res_d = '0;
            w_exc_d = 1'b1;
        end else begin
            w_res_d = r_neg ? -w_quo_mag : w_quo_mag;
            w_exc_d = !r_neg && w_quo_mag[WIDTH-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_en    = 1'b0;
        w_finish    = 1'b0;
        if (w_start) begin
            w_state_nxt = (w_op == OP_MUL) ? ST_MULT : ST_DIV;
        end else begin
            case (r_state)
                ST_MULT: begin
                    if (w_cnt_done) begin
                        w_state_nxt = ST_DONE;
                        w_finish    = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                ST_DIV: begin
                    if (r_dz || w_cnt_done) begin
                        w_state_nxt = ST_DONE;
                        w_finish    = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_opa    <= data_operandA;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz     <= (w_op == OP_DIV) && (data_operandB == '0);
            r_result <= '0;
            r_exc    <= 1'b0;
            if (w_op == OP_MUL) begin
                r_opb <= data_operandB;
                r_acc <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            end else begin
                r_opb <= w_abs_b;
                r_acc <= {{(WIDTH+1){1'b0}}, w_abs_a};
            end
        end else if (w_cnt_en) begin
            r_acc <= (r_state == ST_MULT) ? w_booth_nxt : w_div_nxt;
        end else if (w_finish) begin
            r_result <= w_res_d;
            r_exc    <= w_exc_d;
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == ST_DONE);
    assign busy           = (r_state != ST_IDLE);

endmodule
